// File: rtl/vx_barrier_ctrl_pkg.sv
// ============================================================================
// Module   : vx_barrier_ctrl_pkg
// Brief    : Shared sizing, barrier entry types and helpers for the barrier controller.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package vx_barrier_ctrl_pkg;

    localparam int NUM_WARPS    = 4;
    localparam int NUM_BARRIERS = 4;
    localparam int NW_WIDTH     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int NB_WIDTH     = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        WAIT_GLB = 2'd2
    } bar_state_e;

    typedef struct packed {
        bar_state_e            state;
        logic [NW_WIDTH-1:0]   count;
        logic [NUM_WARPS-1:0]  wmask;
        logic                  pend;
    } bar_entry_t;

    // Index of the lowest set bit; zero when the vector is empty.
    function automatic logic [NB_WIDTH-1:0] lowest_set(input logic [NUM_BARRIERS-1:0] vec);
        lowest_set = '0;
        for (int i = NUM_BARRIERS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                lowest_set = NB_WIDTH'(i);
            end
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/vx_barrier_ctrl_if.sv
// ============================================================================
// Module   : vx_barrier_ctrl_if
// Brief    : Barrier arrival, release and cluster gbar handshake bundle.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface vx_barrier_ctrl_if;
    import vx_barrier_ctrl_pkg::*;

    logic                     bar_valid;
    logic [NW_WIDTH-1:0]      bar_wid;
    logic [NB_WIDTH-1:0]      bar_id;
    logic [NW_WIDTH-1:0]      bar_size_m1;
    logic                     bar_is_global;
    logic                     bar_is_noop;
    logic [NUM_WARPS-1:0]     stall_mask;
    logic                     release_valid;
    logic [NUM_WARPS-1:0]     release_mask;
    logic                     gbar_req_valid;
    logic [NB_WIDTH-1:0]      gbar_req_id;
    logic                     gbar_req_ready;
    logic                     gbar_rsp_valid;
    logic [NB_WIDTH-1:0]      gbar_rsp_id;

    modport master (
        output bar_valid, bar_wid, bar_id, bar_size_m1, bar_is_global, bar_is_noop,
        output gbar_req_ready, gbar_rsp_valid, gbar_rsp_id,
        input  stall_mask, release_valid, release_mask, gbar_req_valid, gbar_req_id
    );

    modport slave (
        input  bar_valid, bar_wid, bar_id, bar_size_m1, bar_is_global, bar_is_noop,
        input  gbar_req_ready, gbar_rsp_valid, gbar_rsp_id,
        output stall_mask, release_valid, release_mask, gbar_req_valid, gbar_req_id
    );

endinterface

`default_nettype wire

// File: rtl/vx_barrier_ctrl_gbar_arb.sv
// ============================================================================
// Module   : vx_bar_gbar_arb
// Brief    : Lowest-id pick among pending global barriers, held as a registered request.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vx_bar_gbar_arb
    import vx_barrier_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_BARRIERS-1:0] i_pend,
    input  logic                    i_req_ready,
    output logic                    o_req_valid,
    output logic [NB_WIDTH-1:0]     o_req_id,
    output logic                    o_req_fire
);

    logic                    r_req_valid;
    logic [NB_WIDTH-1:0]     r_req_id;
    logic                    w_fire;
    logic                    w_load;
    logic [NUM_BARRIERS-1:0] w_fired_oh;
    logic [NUM_BARRIERS-1:0] w_avail;

    assign w_fire     = r_req_valid & i_req_ready;
    assign w_load     = !r_req_valid || w_fire;
    // The granted id's pend bit clears on this same edge, so hide it from the next pick.
    assign w_fired_oh = w_fire ? (NUM_BARRIERS'(1) << r_req_id) : '0;
    assign w_avail    = i_pend & ~w_fired_oh;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_req_valid <= 1'b0;
            r_req_id    <= '0;
        end else if (w_load) begin
            r_req_valid <= |w_avail;
            r_req_id    <= lowest_set(w_avail);
        end
    end

    assign o_req_valid = r_req_valid;
    assign o_req_id    = r_req_id;
    assign o_req_fire  = w_fire;

endmodule

`default_nettype wire

// File: rtl/vx_barrier_ctrl.sv
// ============================================================================
// Module   : vx_barrier_ctrl
// Brief    : Per-barrier warp collection, stall tracking and local/global release.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vx_barrier_ctrl
    import vx_barrier_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    vx_barrier_ctrl_if.slave  bus
);

    localparam bar_entry_t c_entry_reset = '{state: IDLE, count: '0, wmask: '0, pend: 1'b0};

    bar_entry_t              r_entry     [NUM_BARRIERS];
    bar_entry_t              w_entry_nxt [NUM_BARRIERS];
    logic                    r_release_valid;
    logic [NUM_WARPS-1:0]    r_release_mask;
    logic [NUM_WARPS-1:0]    r_stall_mask;
    logic                    w_release_valid;
    logic [NUM_WARPS-1:0]    w_release_mask;
    logic [NUM_WARPS-1:0]    w_stall_nxt;

    bar_entry_t              w_arr_cur;
    bar_entry_t              w_rsp_cur;
    logic [NUM_WARPS-1:0]    w_arr_mask;
    logic                    w_arrive;
    logic                    w_dup_err;
    logic                    w_glb_err;
    logic                    w_rsp_ok;
    logic                    w_rsp_err;

    logic [NUM_BARRIERS-1:0] w_pend;
    logic                    w_req_valid;
    logic [NB_WIDTH-1:0]     w_req_id;
    logic                    w_req_fire;

    assign w_arr_cur  = r_entry[bus.bar_id];
    assign w_rsp_cur  = r_entry[bus.gbar_rsp_id];
    assign w_arr_mask = NUM_WARPS'(1) << bus.bar_wid;
    assign w_arrive   = bus.bar_valid && !bus.bar_is_noop;
    assign w_dup_err  = w_arrive && ((w_arr_cur.wmask & w_arr_mask) != '0);
    assign w_glb_err  = w_arrive && (w_arr_cur.state == WAIT_GLB);
    assign w_rsp_ok   = bus.gbar_rsp_valid && (w_rsp_cur.state == WAIT_GLB) && !w_rsp_cur.pend;
    assign w_rsp_err  = bus.gbar_rsp_valid && !w_rsp_ok;

    generate
        for (genvar b = 0; b < NUM_BARRIERS; b++) begin : g_pend
            assign w_pend[b] = r_entry[b].pend;
        end
    endgenerate

    vx_bar_gbar_arb u_gbar_arb (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_pend      (w_pend),
        .i_req_ready (bus.gbar_req_ready),
        .o_req_valid (w_req_valid),
        .o_req_id    (w_req_id),
        .o_req_fire  (w_req_fire)
    );

    always_comb begin
        w_entry_nxt     = r_entry;
        w_release_valid = 1'b0;
        w_release_mask  = '0;

        if (w_req_fire) begin
            w_entry_nxt[w_req_id].pend = 1'b0;
        end

        if (w_rsp_ok) begin
            w_release_valid                 = 1'b1;
            w_release_mask                  = w_rsp_cur.wmask;
            w_entry_nxt[bus.gbar_rsp_id]    = c_entry_reset;
        end

        // A barrier in WAIT_GLB never accepts arrivals, so this cannot collide with the response above.
        if (w_arrive && !w_dup_err && !w_glb_err) begin
            if (w_arr_cur.count >= bus.bar_size_m1) begin
                if (bus.bar_is_global) begin
                    w_entry_nxt[bus.bar_id].state = WAIT_GLB;
                    w_entry_nxt[bus.bar_id].wmask = w_arr_cur.wmask | w_arr_mask;
                    w_entry_nxt[bus.bar_id].count = '0;
                    w_entry_nxt[bus.bar_id].pend  = 1'b1;
                end else begin
                    w_release_valid          = 1'b1;
                    w_release_mask           = w_release_mask | w_arr_cur.wmask | w_arr_mask;
                    w_entry_nxt[bus.bar_id]  = c_entry_reset;
                end
            end else begin
                w_entry_nxt[bus.bar_id].state = COLLECT;
                w_entry_nxt[bus.bar_id].wmask = w_arr_cur.wmask | w_arr_mask;
                w_entry_nxt[bus.bar_id].count = w_arr_cur.count + NW_WIDTH'(1);
            end
        end
    end

    always_comb begin
        w_stall_nxt = '0;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            w_stall_nxt = w_stall_nxt | w_entry_nxt[b].wmask;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                r_entry[b] <= c_entry_reset;
            end
            r_release_valid <= 1'b0;
            r_release_mask  <= '0;
            r_stall_mask    <= '0;
        end else begin
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                r_entry[b] <= w_entry_nxt[b];
            end
            r_release_valid <= w_release_valid;
            r_release_mask  <= w_release_mask;
            r_stall_mask    <= w_stall_nxt;
        end
    end

    assign bus.stall_mask     = r_stall_mask;
    assign bus.release_valid  = r_release_valid;
    assign bus.release_mask   = r_release_mask;
    assign bus.gbar_req_valid = w_req_valid;
    assign bus.gbar_req_id    = w_req_id;

    a_arrival_legal: assert property (@(posedge clk) disable iff (!reset_n) !(w_dup_err || w_glb_err));
    a_rsp_legal:     assert property (@(posedge clk) disable iff (!reset_n) !w_rsp_err);

endmodule

`default_nettype wire
